microwave_ctrl: RTL and testbench
=================================

// Module: microwave_ctrl
// PURPOSE
//  Parametrised microwave controller with an integrated cook timer, tick prescaler, power-level
//  duty cycling and timed beep. Sits between the user inputs (button, door sensor) and the magnetron/buzzer.
//  Replaces the fixed-width, fixed-30 s SM + external timer pair; timer and duty counters are internal.
// PARAMETERS
//  TMR_W      7   width of the cook timer (ticks)
//  ADD_TICKS  30  ticks loaded or added per button press
//  MAX_TICKS  99  timer saturation value; must be < 2**TMR_W
//  TICK_DIV   1   clocks per timer tick; 1 = decrement every clock
//  BEEP_CLKS  4   clocks spent in BEEP
//  PWR_STEPS  4   duty period in clocks; pwr_lvl==PWR_STEPS means full power
// PORTS
//  clk      in   1                      system clock
//  rst_n    in   1                      asynchronous active-low reset
//  press    in   1                      Add button, level; rising edge acts
//  open     in   1                      door open sensor, level
//  pwr_lvl  in   $clog2(PWR_STEPS+1)    power level 0..PWR_STEPS; values >PWR_STEPS treated as PWR_STEPS
//  cancel   in   1                      stop/clear (present only with MW_CANCEL_EN)
//  on       out  1                      magnetron enable
//  beep     out  1                      buzzer
//  cooking  out  1                      state==COOK (regardless of duty)
//  tmr      out  TMR_W                  remaining cook ticks
//  tmr_zr   out  1                      tmr==0
// BEHAVIOUR
//  Reset: state=IDLE, tmr=0, tick/duty/beep counters=0, press_q=0; on=beep=cooking=0, tmr_zr=1.
//  press_rise = press & ~press_q (comb.); acts at the same posedge it is sampled; held press adds once.
//  Add: tmr <= min(tmr+ADD_TICKS, MAX_TICKS), computed at TMR_W+1 bits, no wrap.
//  States IDLE, COOK, PAUSE, BEEP. Priority within every state: open > press_rise > timer events.
//   IDLE : press_rise -> tmr=ADD_TICKS; next PAUSE if open, else COOK.
//   COOK : open -> PAUSE (tmr held; press_rise same cycle still adds); press_rise -> add, stay;
//          tmr_zr -> BEEP, beep_cnt=BEEP_CLKS-1; else tick_cnt counts 0..TICK_DIV-1, tmr-- when it wraps.
//   PAUSE: press_rise -> add; !open & !tmr_zr -> COOK; !open & tmr_zr -> IDLE.
//   BEEP : open -> IDLE; press_rise -> tmr=ADD_TICKS, COOK (PAUSE if open; open+press both act);
//          beep_cnt==0 -> IDLE; else beep_cnt--.
//  tick_cnt and duty_cnt clear on every entry to COOK; neither advances outside COOK. tmr never decrements below 0.
//  on = cooking & (duty_cnt < pwr_lvl); duty_cnt wraps 0..PWR_STEPS-1. pwr_lvl=0 -> on stays 0 while COOK still times down.
//  beep = (state==BEEP). All outputs registered/decoded from flops; no comb. path from inputs to outputs.
//  Expiry: tmr reaches 0 at the tick edge; next edge enters BEEP (one COOK cycle with tmr_zr=1, on may be 1).
//  rst_n asserted mid-operation: immediate return to reset values, no BEEP.
// CONFIGURATION
//  `MW_CANCEL_EN defined: cancel port present; cancel=1 in any state -> IDLE, tmr=0, all counters 0
//   at next edge; highest priority (above open/press).
//  Undefined: no cancel port; the only exits to IDLE are BEEP completion, open in BEEP, and PAUSE close with tmr_zr.
// STRUCTURE
//  microwave_pkg: typedef enum logic [1:0] {IDLE,COOK,PAUSE,BEEP} mw_state_t; shared with bench.
//  Sub-module mw_tick_gen (TICK_DIV prescaler: clr, en -> tick pulse); duty and beep counters inline.
// TESTING (TICK_DIV=1, ADD=30, MAX=99, BEEP=4, PWR_STEPS=4, pwr_lvl=4 unless stated)
//  Reset, idle 2 clks -> on=0, beep=0, tmr=0; press 1 clk -> COOK, tmr=30, on=1.
//  Cook 2 clks, open=1 -> PAUSE, on=0, tmr<=28 held; press -> tmr<=58; close -> COOK, on=1.
//  Hold press 10 clks in COOK -> exactly one add; 4 adds from 30 -> tmr saturates at 99.
//  Let timer expire -> beep=1 for 4 clks then IDLE, tmr=0; press during BEEP -> COOK, tmr=30, beep=0.
//  pwr_lvl=1 -> on pattern 1000 repeating in COOK; pwr_lvl=0 -> on=0, tmr still decrements.
//  MW_CANCEL_EN: cancel mid-COOK -> IDLE, tmr=0, on=0 next clk; reset mid-BEEP -> all outputs at reset values.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared types for the microwave controller and its bench.
package microwave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2,
        BEEP  = 2'd3
    } mw_state_t;

endpackage

// File: rtl/mw_tick_gen.sv
// Timer-tick prescaler: counts enabled clocks and pulses tick every TICK_DIV of them.
module mw_tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_reg;

    assign tick = en & (cnt_reg == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave controller: cook timer, tick prescaler, power duty cycling and timed beep.
// Optional cancel input enabled by defining MW_CANCEL_EN.
module microwave_ctrl
    import microwave_pkg::*;
#(
    parameter int TMR_W     = 7,
    parameter int ADD_TICKS = 30,
    parameter int MAX_TICKS = 99,
    parameter int TICK_DIV  = 1,
    parameter int BEEP_CLKS = 4,
    parameter int PWR_STEPS = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           press,
    input  logic                           open,
    input  logic [$clog2(PWR_STEPS+1)-1:0] pwr_lvl,
`ifdef MW_CANCEL_EN
    input  logic                           cancel,
`endif
    output logic                           on,
    output logic                           beep,
    output logic                           cooking,
    output logic [TMR_W-1:0]               tmr,
    output logic                           tmr_zr
);

    localparam int PW = $clog2(PWR_STEPS + 1);
    localparam int BW = (BEEP_CLKS > 1) ? $clog2(BEEP_CLKS) : 1;
    localparam logic [TMR_W:0]   ADD_W     = (TMR_W+1)'(ADD_TICKS);
    localparam logic [TMR_W:0]   MAX_W     = (TMR_W+1)'(MAX_TICKS);
    localparam logic [TMR_W-1:0] ADD_T     = TMR_W'(ADD_TICKS);
    localparam logic [TMR_W-1:0] MAX_T     = TMR_W'(MAX_TICKS);
    localparam logic [PW-1:0]    STEPS_P   = PW'(PWR_STEPS);
    localparam logic [PW-1:0]    DUTY_LAST = PW'(PWR_STEPS - 1);
    localparam logic [BW-1:0]    BEEP_LAST = BW'(BEEP_CLKS - 1);

    mw_state_t         state_reg, state_next;
    logic [TMR_W-1:0]  tmr_reg, tmr_next;
    logic [BW-1:0]     beep_cnt_reg, beep_cnt_next;
    logic [PW-1:0]     duty_reg, duty_next;
    logic              on_reg, on_next;
    logic              press_q;

    logic              press_rise;
    logic              cancel_act;
    logic              tmr_zr_int;
    logic [TMR_W:0]    tmr_sum;
    logic [TMR_W-1:0]  tmr_add;
    logic [PW-1:0]     pwr_eff;
    logic              entering_cook;
    logic              tick_en;
    logic              tick_clr;
    logic              tick;

`ifdef MW_CANCEL_EN
    assign cancel_act = cancel;
`else
    assign cancel_act = 1'b0;
`endif

    assign press_rise = press & ~press_q;
    assign tmr_zr_int = (tmr_reg == '0);

    // Saturating add done one bit wider so the sum can never wrap.
    assign tmr_sum = {1'b0, tmr_reg} + ADD_W;
    assign tmr_add = (tmr_sum > MAX_W) ? MAX_T : tmr_sum[TMR_W-1:0];

    assign pwr_eff = (pwr_lvl > STEPS_P) ? STEPS_P : pwr_lvl;

    // The prescaler only runs on COOK cycles that are not taken by a higher-priority event.
    assign tick_en = (state_reg == COOK) & ~cancel_act & ~open & ~press_rise & ~tmr_zr_int;

    mw_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .en    (tick_en),
        .tick  (tick)
    );

    always_comb begin
        state_next    = state_reg;
        tmr_next      = tmr_reg;
        beep_cnt_next = beep_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (press_rise) begin
                    tmr_next   = ADD_T;
                    state_next = open ? PAUSE : COOK;
                end
            end
            COOK: begin
                if (open) begin
                    state_next = PAUSE;
                    if (press_rise) tmr_next = tmr_add;
                end else if (press_rise) begin
                    tmr_next = tmr_add;
                end else if (tmr_zr_int) begin
                    state_next    = BEEP;
                    beep_cnt_next = BEEP_LAST;
                end else if (tick) begin
                    tmr_next = tmr_reg - 1'b1;
                end
            end
            PAUSE: begin
                if (press_rise) tmr_next = tmr_add;
                // Closing the door resumes only if there is time left after any same-cycle add.
                if (!open) state_next = (tmr_next == '0) ? IDLE : COOK;
            end
            BEEP: begin
                if (press_rise) begin
                    tmr_next   = ADD_T;
                    state_next = open ? PAUSE : COOK;
                end else if (open) begin
                    state_next = IDLE;
                end else if (beep_cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    beep_cnt_next = beep_cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (cancel_act) begin
            state_next    = IDLE;
            tmr_next      = '0;
            beep_cnt_next = '0;
        end
    end

    assign entering_cook = (state_next == COOK) && (state_reg != COOK);
    assign tick_clr      = cancel_act | entering_cook;

    always_comb begin
        duty_next = duty_reg;
        if (cancel_act || entering_cook) begin
            duty_next = '0;
        end else if (state_next == COOK) begin
            duty_next = (duty_reg == DUTY_LAST) ? '0 : duty_reg + 1'b1;
        end
        // Registering the enable keeps pwr_lvl off any combinational path to the pins.
        on_next = (state_next == COOK) && (duty_next < pwr_eff);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            tmr_reg      <= '0;
            beep_cnt_reg <= '0;
            duty_reg     <= '0;
            on_reg       <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tmr_reg      <= tmr_next;
            beep_cnt_reg <= beep_cnt_next;
            duty_reg     <= duty_next;
            on_reg       <= on_next;
            press_q      <= press;
        end
    end

    assign on      = on_reg;
    assign beep    = (state_reg == BEEP);
    assign cooking = (state_reg == COOK);
    assign tmr     = tmr_reg;
    assign tmr_zr  = tmr_zr_int;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Scoreboard bench for microwave_ctrl: stimulus queues expected outputs, a monitor checks them.
module tb_microwave_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       press;
    logic       open;
    logic [2:0] pwr_lvl;
    logic [2:0] pwr_cfg;
    logic       on, beep, cooking, tmr_zr;
    logic [6:0] tmr;
`ifdef MW_CANCEL_EN
    logic       cancel;
    logic       cancel_cfg;
`endif

    typedef struct {
        string      name;
        logic       on;
        logic       beep;
        logic       cooking;
        logic [6:0] tmr;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   tstart;

    always #5 clk = ~clk;

    microwave_ctrl #(
        .TMR_W     (7),
        .ADD_TICKS (30),
        .MAX_TICKS (99),
        .TICK_DIV  (1),
        .BEEP_CLKS (4),
        .PWR_STEPS (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .press   (press),
        .open    (open),
        .pwr_lvl (pwr_lvl),
`ifdef MW_CANCEL_EN
        .cancel  (cancel),
`endif
        .on      (on),
        .beep    (beep),
        .cooking (cooking),
        .tmr     (tmr),
        .tmr_zr  (tmr_zr)
    );

    // Drive one clock of inputs and queue what the outputs must be just after that edge.
    task automatic step(input string nm, input logic r, input logic p, input logic o,
                        input logic e_on, input logic e_beep, input logic e_cook, input int e_tmr);
        exp_t e;
        @(negedge clk);
        rst_n   = r;
        press   = p;
        open    = o;
        pwr_lvl = pwr_cfg;
`ifdef MW_CANCEL_EN
        cancel  = cancel_cfg;
`endif
        e.name    = nm;
        e.on      = e_on;
        e.beep    = e_beep;
        e.cooking = e_cook;
        e.tmr     = 7'(e_tmr);
        sb_q.push_back(e);
        @(posedge clk);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [10:0] act, req;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {on, beep, cooking, tmr_zr, tmr};
                req = {e.on, e.beep, e.cooking, (e.tmr == 7'd0), e.tmr};
                checks++;
                if (act !== req) begin
                    errors++;
                    $display("FAIL %s: got on=%b beep=%b cooking=%b tmr_zr=%b tmr=%0d, want on=%b beep=%b cooking=%b tmr_zr=%b tmr=%0d",
                             e.name, on, beep, cooking, tmr_zr, tmr,
                             req[10], req[9], req[8], req[7], e.tmr);
                end else begin
                    $display("check %s: on=%b beep=%b cooking=%b tmr=%0d ok",
                             e.name, on, beep, cooking, tmr);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_n   = 1'b0;
        press   = 1'b0;
        open    = 1'b0;
        pwr_cfg = 3'd4;
        pwr_lvl = 3'd4;
`ifdef MW_CANCEL_EN
        cancel_cfg = 1'b0;
        cancel     = 1'b0;
`endif
        step("rst_a", 0, 0, 0, 0, 0, 0, 0);
        step("rst_b", 0, 0, 0, 0, 0, 0, 0);
        step("idle_a", 1, 0, 0, 0, 0, 0, 0);
        step("idle_b", 1, 0, 0, 0, 0, 0, 0);

        step("start", 1, 1, 0, 1, 0, 1, 30);
        step("cook_a", 1, 0, 0, 1, 0, 1, 29);
        step("cook_b", 1, 0, 0, 1, 0, 1, 28);
        step("open_pause", 1, 0, 1, 0, 0, 0, 28);
        step("pause_add", 1, 1, 1, 0, 0, 0, 58);
        step("close_cook", 1, 0, 0, 1, 0, 1, 58);

        step("hold_add", 1, 1, 0, 1, 0, 1, 88);
        for (int k = 1; k <= 9; k++) step("hold_no_add", 1, 1, 0, 1, 0, 1, 88 - k);
        step("release", 1, 0, 0, 1, 0, 1, 78);
        step("add_sat_a", 1, 1, 0, 1, 0, 1, 99);
        step("release", 1, 0, 0, 1, 0, 1, 98);
        step("add_sat_b", 1, 1, 0, 1, 0, 1, 99);
        step("release", 1, 0, 0, 1, 0, 1, 98);

        for (int k = 97; k >= 0; k--) step("countdown", 1, 0, 0, 1, 0, 1, k);
        step("beep_1", 1, 0, 0, 0, 1, 0, 0);
        step("beep_2", 1, 0, 0, 0, 1, 0, 0);
        step("beep_3", 1, 0, 0, 0, 1, 0, 0);
        step("beep_4", 1, 0, 0, 0, 1, 0, 0);
        step("beep_done", 1, 0, 0, 0, 0, 0, 0);

        step("start2", 1, 1, 0, 1, 0, 1, 30);
        for (int k = 29; k >= 0; k--) step("countdown2", 1, 0, 0, 1, 0, 1, k);
        step("beep2_1", 1, 0, 0, 0, 1, 0, 0);
        step("beep2_2", 1, 0, 0, 0, 1, 0, 0);
        step("beep_press", 1, 1, 0, 1, 0, 1, 30);

        pwr_cfg = 3'd1;
        for (int k = 0; k < 8; k++) step("pwr1", 1, 0, 0, (k % 4) == 3, 0, 1, 29 - k);
        pwr_cfg = 3'd0;
        for (int k = 0; k < 4; k++) step("pwr0", 1, 0, 0, 0, 0, 1, 21 - k);
        pwr_cfg = 3'd4;

`ifdef MW_CANCEL_EN
        cancel_cfg = 1'b1;
        step("cancel", 1, 0, 0, 0, 0, 0, 0);
        cancel_cfg = 1'b0;
        step("restart", 1, 1, 0, 1, 0, 1, 30);
        tstart = 30;
`else
        tstart = 18;
`endif
        for (int k = tstart - 1; k >= 0; k--) step("countdown3", 1, 0, 0, 1, 0, 1, k);
        step("beep3_1", 1, 0, 0, 0, 1, 0, 0);
        step("rst_mid_beep", 0, 0, 0, 0, 0, 0, 0);
        step("rst_hold", 0, 0, 0, 0, 0, 0, 0);
        step("rst_release", 1, 0, 0, 0, 0, 0, 0);

        step("idle_open_press", 1, 1, 1, 0, 0, 0, 30);
        step("pause_close", 1, 0, 0, 1, 0, 1, 30);
        step("cook_after", 1, 0, 0, 1, 0, 1, 29);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
